// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the AddSub ALU, the result queue, the CDB arbiter and the flush source.
// The slave side is the queue; the master side is everything around it.
interface alu_result_queue_if #(
  parameter int DEPTH         = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                       in_valid;
  logic [ROB_IDX_WIDTH-1:0]   in_rob_idx;
  logic [DATA_WIDTH-1:0]      in_result;
  logic                       in_ready;
  logic                       cdb_valid;
  logic [ROB_IDX_WIDTH-1:0]   cdb_rob_idx;
  logic [DATA_WIDTH-1:0]      cdb_result;
  logic                       cdb_grant;
  logic                       flush_valid;
  logic [ROB_IDX_WIDTH-1:0]   flush_rob_idx;
  logic [ROB_IDX_WIDTH-1:0]   rob_head;
  logic [$clog2(DEPTH):0]     occupancy;

  modport slave (
    input  in_valid, in_rob_idx, in_result, cdb_grant,
           flush_valid, flush_rob_idx, rob_head,
    output in_ready, cdb_valid, cdb_rob_idx, cdb_result, occupancy
  );

  modport master (
    output in_valid, in_rob_idx, in_result, cdb_grant,
           flush_valid, flush_rob_idx, rob_head,
    input  in_ready, cdb_valid, cdb_rob_idx, cdb_result, occupancy
  );
endinterface

// File: rtl/alu_result_queue.sv
// In-order queue of AddSub ALU results feeding one CDB request port.
// Entries younger than a mispredicted branch are marked dead and drained silently.
module alu_result_queue #(
  parameter int DEPTH         = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ROB_IDX_WIDTH-1:0] rob_q  [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0]         live_q;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;

  logic                     not_empty;
  logic                     head_live;
  logic                     push;
  logic                     pop;
  logic [ROB_IDX_WIDTH-1:0] flush_age;
  logic                     in_squashed;

  // Age relative to the ROB head, so comparisons survive ROB index wrap.
  function automatic logic [ROB_IDX_WIDTH-1:0] age(input logic [ROB_IDX_WIDTH-1:0] x,
                                                   input logic [ROB_IDX_WIDTH-1:0] head);
    return x - head;
  endfunction

  always_comb begin
    not_empty   = (count != '0);
    head_live   = not_empty && live_q[rd_ptr];
    bus.in_ready    = (count < CW'(DEPTH)) && !rst;
    push        = bus.in_valid && bus.in_ready;
    // A dead head leaves without a grant; a live head needs one.
    pop         = not_empty && (!live_q[rd_ptr] || bus.cdb_grant);
    flush_age   = age(bus.flush_rob_idx, bus.rob_head);
    in_squashed = bus.flush_valid && (age(bus.in_rob_idx, bus.rob_head) > flush_age);
    bus.cdb_valid   = head_live && !rst;
    bus.cdb_rob_idx = rob_q[rd_ptr];
    bus.cdb_result  = data_q[rd_ptr];
    bus.occupancy   = rst ? '0 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (bus.flush_valid && (age(rob_q[i], bus.rob_head) > flush_age))
          live_q[i] <= 1'b0;
      end
      if (push) begin
        rob_q[wr_ptr]  <= bus.in_rob_idx;
        data_q[wr_ptr] <= bus.in_result;
        live_q[wr_ptr] <= !in_squashed;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: one task per scenario, inline comparisons.
module tb_alu_result_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_viol  = 0;

  alu_result_queue_if #(.DEPTH(4), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32)) bus ();

  alu_result_queue #(.DEPTH(4), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Pushes offered while the queue cannot accept them.
  always @(posedge clk) if (!rst && bus.in_valid && !bus.in_ready) n_viol++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [4:0] rob, input logic [31:0] data);
    bus.in_valid = 1'b1; bus.in_rob_idx = rob; bus.in_result = data;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_tests++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid got %b want 0", bus.cdb_valid); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.cdb_grant = 1'b1;
    bus.in_valid = 1'b1; bus.in_rob_idx = 5'd5; bus.in_result = 32'h0000_000A;
    #1;
    n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", bus.cdb_valid); end
    step();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'd5 || bus.cdb_result !== 32'h0000_000A) begin
      n_fail++; $display("FAIL single_head got v=%b rob=%0d res=%h want v=1 rob=5 res=0000000a", bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_result);
    end
    step();
    n_tests++; if (bus.occupancy !== 3'd0 || bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_popped got occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.cdb_valid);
    end
    bus.cdb_grant = 1'b0;
  endtask

  task automatic test_fill_drain();
    bus.cdb_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push_hold(5'(i), 32'h100 + 32'(i));
    n_tests++; if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ got %0d want 4", bus.occupancy); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
    step();
    n_tests++; if (bus.cdb_rob_idx !== 5'd1 || bus.cdb_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_head_stable got v=%b rob=%0d want v=1 rob=1", bus.cdb_valid, bus.cdb_rob_idx);
    end
    bus.cdb_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'(i) || bus.cdb_result !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL drain_order got v=%b rob=%0d res=%h want v=1 rob=%0d res=%h",
                           bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_result, i, 32'h100 + 32'(i));
      end
      step();
      if (i == 1) begin
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready got %b want 1", bus.in_ready); end
      end
    end
    n_tests++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_occ got %0d want 0", bus.occupancy); end
    bus.cdb_grant = 1'b0;
  endtask

  task automatic test_full_push_pop();
    bus.cdb_grant = 1'b0;
    for (int i = 10; i <= 13; i++) push_hold(5'(i), 32'hA00 + 32'(i));
    bus.cdb_grant = 1'b1;
    bus.in_valid = 1'b1; bus.in_rob_idx = 5'd20; bus.in_result = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.occupancy !== 3'd3 || bus.cdb_rob_idx !== 5'd11) begin
      n_fail++; $display("FAIL full_pop_only got occ=%0d rob=%0d want occ=3 rob=11", bus.occupancy, bus.cdb_rob_idx);
    end
    for (int i = 11; i <= 13; i++) begin
      n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'(i)) begin
        n_fail++; $display("FAIL full_drain got v=%b rob=%0d want v=1 rob=%0d", bus.cdb_valid, bus.cdb_rob_idx, i);
      end
      step();
    end
    n_tests++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL full_rejected_occ got %0d want 0", bus.occupancy); end
    n_tests++; if (n_viol !== 1) begin n_fail++; $display("FAIL protocol_violation_count got %0d want 1", n_viol); end
    bus.cdb_grant = 1'b0;
  endtask

  task automatic test_squash();
    bus.rob_head = 5'd30; bus.cdb_grant = 1'b0;
    push_hold(5'd31, 32'h31); push_hold(5'd1, 32'h01); push_hold(5'd3, 32'h03);
    bus.flush_valid = 1'b1; bus.flush_rob_idx = 5'd1;
    step();
    bus.flush_valid = 1'b0;
    n_tests++; if (bus.occupancy !== 3'd3 || bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'd31) begin
      n_fail++; $display("FAIL squash_hold got occ=%0d v=%b rob=%0d want occ=3 v=1 rob=31", bus.occupancy, bus.cdb_valid, bus.cdb_rob_idx);
    end
    bus.cdb_grant = 1'b1;
    step();
    n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'd1) begin
      n_fail++; $display("FAIL squash_survivor got v=%b rob=%0d want v=1 rob=1", bus.cdb_valid, bus.cdb_rob_idx);
    end
    step();
    n_tests++; if (bus.cdb_valid !== 1'b0 || bus.occupancy !== 3'd1) begin
      n_fail++; $display("FAIL squash_dead_head got v=%b occ=%0d want v=0 occ=1", bus.cdb_valid, bus.occupancy);
    end
    step();
    n_tests++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL squash_drained got occ=%0d want 0", bus.occupancy); end
    bus.cdb_grant = 1'b0; bus.rob_head = 5'd0;
  endtask

  task automatic test_flush_push();
    bus.rob_head = 5'd0; bus.flush_rob_idx = 5'd6; bus.flush_valid = 1'b1;
    bus.cdb_grant = 1'b0;
    push_hold(5'd9, 32'h99);
    n_tests++; if (bus.occupancy !== 3'd1 || bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_push_young got occ=%0d v=%b want occ=1 v=0", bus.occupancy, bus.cdb_valid);
    end
    push_hold(5'd4, 32'h44);
    bus.flush_valid = 1'b0;
    n_tests++; if (bus.occupancy !== 3'd1 || bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'd4 || bus.cdb_result !== 32'h44) begin
      n_fail++; $display("FAIL flush_push_old got occ=%0d v=%b rob=%0d res=%h want occ=1 v=1 rob=4 res=00000044",
                         bus.occupancy, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_result);
    end
    bus.cdb_grant = 1'b1;
    step();
    n_tests++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_push_done got occ=%0d want 0", bus.occupancy); end
    bus.cdb_grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.cdb_grant = 1'b0;
    push_hold(5'd7, 32'h7); push_hold(5'd8, 32'h8); push_hold(5'd9, 32'h9);
    n_tests++; if (bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL mid_pre_occ got %0d want 3", bus.occupancy); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.cdb_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs got v=%b rdy=%b want v=0 rdy=0", bus.cdb_valid, bus.in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.occupancy !== 3'd0 || bus.cdb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_after_rst got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", bus.occupancy, bus.cdb_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.cdb_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_hold(5'(16 + i), 32'hC0DE_0000 + 32'(i));
      n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_idx !== 5'(16 + i) ||
                     bus.cdb_result !== 32'hC0DE_0000 + 32'(i) || bus.occupancy !== 3'd1) begin
        n_fail++; $display("FAIL wrap_order got v=%b rob=%0d res=%h occ=%0d want v=1 rob=%0d res=%h occ=1",
                           bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_result, bus.occupancy, 16 + i, 32'hC0DE_0000 + 32'(i));
      end
    end
    step();
    n_tests++; if (bus.occupancy !== 3'd0 || bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_empty got occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.cdb_valid);
    end
    bus.cdb_grant = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_rob_idx = '0; bus.in_result = '0;
    bus.cdb_grant = 1'b0; bus.flush_valid = 1'b0; bus.flush_rob_idx = '0; bus.rob_head = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_squash();
    test_flush_push();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Sits directly downstream of the combinational AddSub ALU and stores its results (ROB index + 32-bit value) in a small in-order queue.
- Drives one CDB request port; the CDB arbiter grants it with cdb_grant.
- Decouples ALU execution from CDB contention and squashes results younger than a mispredicted branch.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- ROB_IDX_WIDTH, $clog2(no_ROB), width of ROB index fields
- DATA_WIDTH, 32, result width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ALU result valid (the ALU's result_ready)
- in_rob_idx  input  ROB_IDX_WIDTH  ROB index of the ALU result
- in_result  input  DATA_WIDTH  ALU result value
- in_ready  output  1  queue can accept a result this cycle; issue logic must not fire the ALU when low
- cdb_valid  output  1  head entry requests the CDB
- cdb_rob_idx  output  ROB_IDX_WIDTH  head entry ROB index
- cdb_result  output  DATA_WIDTH  head entry value
- cdb_grant  input  1  arbiter accepts the head entry this cycle
- flush_valid  input  1  branch mispredict squash request
- flush_rob_idx  input  ROB_IDX_WIDTH  ROB index of the mispredicted branch
- rob_head  input  ROB_IDX_WIDTH  current ROB head, used for age comparison
- occupancy  output  $clog2(DEPTH)+1  entries held, including squashed entries not yet drained

Behaviour:
- Storage:
  - Circular buffer with wr_ptr, rd_ptr and count.
  - Each entry holds {live, rob_idx, result}.
- Reset (rst=1 at a clock edge):
  - count=0, pointers=0, all live=0.
  - Outputs while rst is high: cdb_valid=0, in_ready=0, occupancy=0.
  - A reset asserted mid-operation discards all entries; no CDB request appears in the cycle after reset.
- in_ready:
  - Combinational: (count < DEPTH) && !rst.
  - No write-through when full: a same-cycle pop does not enable a push into a full queue.
- Push:
  - When in_valid && in_ready, the entry is written at wr_ptr with live=1 and wr_ptr increments modulo DEPTH.
  - in_valid while in_ready=0 is a protocol violation; the data is dropped and the bench flags an assertion.
- Latency: a pushed entry reaches the head no earlier than the next cycle. There is no combinational in-to-cdb bypass.
- Head output:
  - cdb_valid = (count>0) && live[rd_ptr].
  - cdb_rob_idx and cdb_result come from the rd_ptr entry.
  - Outputs are stable while cdb_valid=1 and cdb_grant=0.
- Pop:
  - When cdb_valid && cdb_grant, rd_ptr advances and count decrements.
  - cdb_grant with cdb_valid=0 is ignored.
- Drain of squashed entries:
  - When count>0 and live[rd_ptr]=0, the entry pops automatically that cycle with cdb_valid=0.
  - One entry drains per cycle.
- Age function: age(x) = (x - rob_head) mod 2^ROB_IDX_WIDTH.
- Squash (flush_valid=1):
  - Every stored entry with age(rob_idx) > age(flush_rob_idx) gets live cleared at the edge.
  - Entries with age <= flush age (older, or the branch itself) survive.
- Simultaneous events in a flush cycle:
  - Incoming push: if in_rob_idx is younger, it is written with live=0 and still occupies a slot; otherwise it is written live.
  - Head pop with grant: allowed. The arbiter guarantees a granted head is never younger than the flush.
- Counter update: count_next = count + push - pop, where pop covers both a granted pop and an auto-drain.
- Wrap-around: pointers wrap modulo DEPTH. count distinguishes full from empty.
- occupancy = count (registered).

Test Plan:
- Reset then push {rob 5, 0x0000_000A} with cdb_grant held 1 -> cdb_valid=1 with rob 5 / 0x0000000A exactly one cycle after the push, popped the next edge; occupancy returns to 0.
- Push 4 results (rob 1..4) with grant=0 -> occupancy=4, in_ready=0, cdb_rob_idx stays 1. Drive grant=1 for 4 cycles -> rob 1,2,3,4 in order, in_ready=1 after the first pop.
- Full queue, grant=1 and in_valid=1 in the same cycle -> push rejected (in_ready=0), pop occurs, occupancy=3.
- rob_head=30 (ROB_IDX_WIDTH=5), queued rob 31,1,3; flush_rob_idx=1 -> rob 31 and 1 survive, 3 squashed. With grant=1: CDB sees 31 then 1; rob 3 drains with cdb_valid=0; occupancy reaches 0 after 3 cycles.
- flush_valid with same-cycle push of rob 9 (rob_head=0, flush_rob_idx=6) -> rob 9 occupies a slot but never asserts cdb_valid. A same-cycle push of rob 4 is delivered.
- Queue holding 3 entries with grant=0, then rst=1 for one cycle -> occupancy=0, cdb_valid=0, in_ready=1 the cycle after rst deasserts; a pointer-wrap run of 10 push/pop pairs afterwards preserves order.
